synth_param_bank: RTL
=====================

Name: synth_param_bank

Overview:
Parametrised bank of NUM_PARAMS user-adjustable synth settings (octave, volume, A/D/S/R, …) driven by a selector plus increment/decrement controls from the PS2 or key front end.
- Replaces ad-hoc per-register add/subtract logic with per-parameter min/max saturation and per-parameter defaults.
- Applies exactly one step per press, then auto-repeats while the control is held.
- Supports direct load and exposes the selected value for HEX/VGA readback.
- Outputs feed the ALU controller and display logic directly.

Parameters:
NUM_PARAMS, 6, number of stored parameters (1..8)
SEL_W, 3, selector width; must satisfy 2^SEL_W >= NUM_PARAMS
WIDTH, 31, bits per parameter
STEP, 10, increment/decrement amount per step (unsigned, < 2^WIDTH)
HOLD_CYCLES, 25000000, cycles a control must be held after the first step before auto-repeat starts (>=1)
REPEAT_CYCLES, 5000000, cycles between auto-repeat steps (>=1)
DEFAULTS, {NUM_PARAMS*WIDTH}'0, packed reset values; param i at [i*WIDTH +: WIDTH]
MINS, {NUM_PARAMS*WIDTH}'0, packed per-param lower bounds
MAXS, all-ones, packed per-param upper bounds; MINS[i] <= DEFAULTS[i] <= MAXS[i]

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-low reset
sel  in  SEL_W  index of the parameter to adjust
inc  in  1  level; increment request (synchronous to clk)
dec  in  1  level; decrement request
load  in  1  single-cycle pulse; write load_value to param[sel]
load_value  in  WIDTH  direct-load value
params  out  NUM_PARAMS*WIDTH  packed registered parameter values
sel_value  out  WIDTH  registered copy of params[sel]
sel_valid  out  1  1 when sel < NUM_PARAMS
changed  out  1  one-cycle pulse when any parameter value actually changed
at_limit  out  1  1 when params[sel] == MINS[sel] or == MAXS[sel]

Behaviour:
- Clock is clk; reset is synchronous, active-low.
- Reset (reset==0 at a posedge):
  - params = DEFAULTS; FSM = IDLE; hold/repeat counter = 0.
  - changed = 0; sel_value = DEFAULTS[sel]; prev_dir = none.
- Direction: dir = UP if inc&~dec, DOWN if dec&~inc, otherwise NONE. inc&dec together counts as NONE.
- FSM states:
  - IDLE: dir != NONE and sel_valid → apply one step to params[sel], latch dir and sel, clear counter, go to HOLD.
  - HOLD: counter increments each cycle. When counter reaches HOLD_CYCLES-1 → apply step, clear counter, go to REPEAT.
  - REPEAT: counter increments each cycle. When it reaches REPEAT_CYCLES-1 → apply step, clear counter, stay in REPEAT.
  - HOLD/REPEAT exit: dir differs from latched dir (release, reversal or both pressed) → go to IDLE with no step. A reversal is taken as a new press on the following IDLE cycle.
  - HOLD/REPEAT on sel change: go to WAIT_REL with no step.
  - WAIT_REL: stay until dir == NONE, then go to IDLE. No steps are applied in this state.
- Step arithmetic, computed in WIDTH+1 bits:
  - UP: new = min(val+STEP, MAXS[i]).
  - DOWN: new = (val < MINS[i]+STEP) ? MINS[i] : val-STEP.
  - No wrap-around, ever.
- Load: load=1 with sel_valid writes clamp(load_value, MINS[sel], MAXS[sel]) to params[sel].
  - Load has priority over a step in the same cycle; the step is dropped.
  - FSM state and counters are unaffected.
- sel >= NUM_PARAMS:
  - No writes; sel_valid=0; sel_value=0; at_limit=0.
  - The FSM still tracks press/release but applies no step.
- Latency:
  - A write decided in cycle t is visible on params at t+1.
  - sel_value and at_limit are registered and reflect params[sel] at t+2.
- changed: asserted at t+1 only if the new value differs from the old. Clamped-at-limit steps and loads of an identical value give changed=0.
- Reset mid-operation: reset asserted in HOLD/REPEAT returns everything to reset values. A control still held when reset is released is treated as a new press, giving one step on the first IDLE cycle.

Test Plan:
(Bench configuration: HOLD_CYCLES=4, REPEAT_CYCLES=2, WIDTH=8, STEP=10, NUM_PARAMS=6, DEFAULTS all 100, MINS 0, MAXS 250 except param 0: MIN 0, MAX 7, DEFAULT 4.)
1. Reset then idle 5 cycles → params all 100 except param0=4; changed=0; sel=2 gives sel_value=100 and sel_valid=1.
2. sel=2, inc high 1 cycle → param2=110 at t+1, changed pulse of 1 cycle, no further steps; other params unchanged.
3. sel=2, inc held 12 cycles from 100 → steps at t, t+4, t+6, t+8, t+10 → 150; release → no further change.
4. sel=0, inc held long from 4 → 7 then saturates (changed=0 after reaching 7, at_limit=1); dec from 5 with STEP=10 → 0, not a wrapped value.
5. inc and dec both high → no change. Hold inc on sel=1, switch sel to 3 mid-HOLD → param3 unchanged until inc is released and pressed again.
6. load=1, sel=4, load_value=255 with inc high in the same cycle → param4=250 (clamped), no extra step. sel=7 with load → no write, sel_valid=0. Reset during REPEAT → all params back to DEFAULTS next cycle.

Source files
------------

// File: rtl/synth_param_bank.sv
// -----------------------------------------------------------------------------
// synth_param_bank
// Bank of NUM_PARAMS user-adjustable synth settings (octave, volume, ADSR, ...).
// A selector picks one parameter; inc/dec levels apply one saturating step per
// press, then auto-repeat after HOLD_CYCLES, every REPEAT_CYCLES. A one-cycle
// load pulse writes a clamped value directly and wins over a same-cycle step.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   sel        index of the parameter to adjust / read back
//   inc, dec   level increment / decrement requests (both high = no request)
//   load       single-cycle pulse: write clamp(load_value) to param[sel]
//   load_value direct-load value
//   params     packed registered parameter values, param i at [i*WIDTH +: WIDTH]
//   sel_value  registered copy of params[sel] (0 when sel is out of range)
//   sel_valid  1 when sel < NUM_PARAMS
//   changed    one-cycle pulse when a write actually altered a value
//   at_limit   registered: params[sel] sits on its min or max bound
// -----------------------------------------------------------------------------
module synth_param_bank #(
  parameter int unsigned NUM_PARAMS    = 6,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned WIDTH         = 31,
  parameter int unsigned STEP          = 10,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = '0,
  parameter logic [NUM_PARAMS*WIDTH-1:0] MINS     = '0,
  parameter logic [NUM_PARAMS*WIDTH-1:0] MAXS     = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        inc,
  input  logic                        dec,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_value,
  output logic [NUM_PARAMS*WIDTH-1:0] params,
  output logic [WIDTH-1:0]            sel_value,
  output logic                        sel_valid,
  output logic                        changed,
  output logic                        at_limit
);

  localparam int unsigned IDX_W   = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH:0]   STEP_X      = (WIDTH+1)'(STEP);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT, ST_WAIT_REL} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  // Unpacked views of the packed parameter vectors.
  logic [WIDTH-1:0] def_a [NUM_PARAMS];
  logic [WIDTH-1:0] min_a [NUM_PARAMS];
  logic [WIDTH-1:0] max_a [NUM_PARAMS];
  logic [WIDTH-1:0] val_q [NUM_PARAMS];

  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_unpack
    assign def_a[i] = DEFAULTS[i*WIDTH +: WIDTH];
    assign min_a[i] = MINS[i*WIDTH +: WIDTH];
    assign max_a[i] = MAXS[i*WIDTH +: WIDTH];
    assign params[i*WIDTH +: WIDTH] = val_q[i];
  end

  state_t           state_q;
  dir_t             dir_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt_q;

  dir_t             dir;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] cur, lo, hi;
  logic [WIDTH-1:0] step_val, load_val, new_val;
  logic [WIDTH:0]   up_x, floor_x;
  logic [CNT_W-1:0] cnt_last;
  logic             same_press, step_fire, write_en;

  assign sel_valid = (32'(sel) < NUM_PARAMS);
  // Out-of-range selectors are folded onto index 0; every use is gated by sel_valid.
  assign sel_idx   = sel_valid ? IDX_W'(sel) : '0;
  assign cur       = val_q[sel_idx];
  assign lo        = min_a[sel_idx];
  assign hi        = max_a[sel_idx];

  assign same_press = (dir == dir_q) && (sel == sel_q);
  assign cnt_last   = (state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    dir       = DIR_NONE;
    step_fire = 1'b0;
    if (inc && !dec)      dir = DIR_UP;
    else if (dec && !inc) dir = DIR_DOWN;

    unique case (state_q)
      ST_IDLE:   step_fire = (dir != DIR_NONE);
      ST_HOLD,
      ST_REPEAT: step_fire = same_press && (cnt_q == cnt_last);
      default:   step_fire = 1'b0;
    endcase
  end

  // Saturating step arithmetic, one bit wider than the value so it never wraps.
  always_comb begin
    up_x    = {1'b0, cur} + STEP_X;
    floor_x = {1'b0, lo} + STEP_X;
    if (dir == DIR_UP) step_val = (up_x > {1'b0, hi}) ? hi : up_x[WIDTH-1:0];
    else               step_val = ({1'b0, cur} < floor_x) ? lo : (cur - STEP_X[WIDTH-1:0]);

    if (load_value < lo)      load_val = lo;
    else if (load_value > hi) load_val = hi;
    else                      load_val = load_value;

    // Load wins: a step requested in the same cycle is dropped.
    new_val  = load ? load_val : step_val;
    write_en = sel_valid && (load || step_fire);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the value bank is reset deliberately: each parameter must come up at
  // its own default, so it cannot be left to power-up contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) val_q[i] <= def_a[i];
      changed   <= 1'b0;
      sel_value <= sel_valid ? def_a[sel_idx] : '0;
      at_limit  <= sel_valid && ((def_a[sel_idx] == lo) || (def_a[sel_idx] == hi));
    end else begin
      if (write_en) val_q[sel_idx] <= new_val;
      changed   <= write_en && (new_val != cur);
      sel_value <= sel_valid ? cur : '0;
      at_limit  <= sel_valid && ((cur == lo) || (cur == hi));
    end
  end

  // Press tracking. Load never touches this machine; steps are decided above
  // from the same state so the two always agree on when a step happens.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (dir != DIR_NONE) begin
            state_q <= ST_HOLD;
            dir_q   <= dir;
            sel_q   <= sel;
            cnt_q   <= '0;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          // Release, reversal or both-pressed ends the press; a reversal is
          // picked up as a fresh press from IDLE on the next cycle.
          if (dir != dir_q)      state_q <= ST_IDLE;
          else if (sel != sel_q) state_q <= ST_WAIT_REL;
          else if (cnt_q == cnt_last) begin
            state_q <= ST_REPEAT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_REL: if (dir == DIR_NONE) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
